div_unit: RTL and testbench
===========================

# div_unit

Iterative radix-2 restoring divider for MIPS DIV/DIVU in the EX stage. Accepts one request from decode/EX and produces signed or unsigned quotient and remainder after a fixed multi-cycle latency. While busy it raises `stall`, which drives the enable/clear controls of the ID/EX and EX/MEM pipeline registers. Results feed the HI/LO write path.

## Interface
- `WIDTH`, default 32: operand and result width.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous active-low reset
- `start`  in  1  request valid; sampled only in IDLE
- `signed_div`  in  1  1 = DIV (two's complement), 0 = DIVU
- `dividend`  in  WIDTH  sampled with `start`
- `divisor`  in  WIDTH  sampled with `start`
- `cancel`  in  1  pipeline flush; aborts any operation
- `stall`  out  1  hold upstream pipeline registers
- `done`  out  1  one-cycle pulse; results valid
- `quotient`  out  WIDTH  registered; holds until next `done`
- `remainder`  out  WIDTH  registered; holds until next `done`

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: if `start & !cancel`, latch |dividend|, |divisor|, the quotient sign (operand signs differ, signed only) and the remainder sign (dividend sign, signed only). Clear the iteration counter and go to BUSY.
- BUSY: each cycle performs one restoring step.
  - Shift the partial remainder left, bringing in the next dividend MSB.
  - Subtract the divisor using a WIDTH+1-bit difference.
  - If the difference is non-negative, keep it and set the quotient bit to 1; otherwise keep the shifted value and set the quotient bit to 0.
  - After WIDTH steps, go to DONE.
- DONE: negate the quotient and/or remainder per the latched signs, register them, pulse `done`, then return to IDLE unconditionally. `start` is ignored in DONE.
- `stall` = (IDLE & `start` & !`cancel`) | BUSY. It is combinational and is low in DONE.
- `cancel` in any state forces IDLE on the next edge. It suppresses `done`, leaves `quotient`/`remainder` unchanged, and has priority over `start`.
- Arithmetic:
  - 0x80000000 / 0xFFFFFFFF (signed) gives q = 0x80000000, r = 0 (natural wrap).
  - Zero divisor on the iterative path gives unsigned q = all-ones and r = |dividend|, followed by the normal sign correction.
- Reset: state IDLE; `quotient` = 0, `remainder` = 0, `done` = 0. `stall` is forced to 0 while `rst` is low. A reset during BUSY discards the operation.

## Timing
- Cycle 0: `start` accepted and `stall` = 1.
- Cycles 1..WIDTH: BUSY, `stall` = 1.
- Cycle WIDTH+1: DONE, `done` = 1, `stall` = 0, results valid on the outputs.
- Cycle WIDTH+2: IDLE. A new `start` can be accepted here.
- Back-to-back throughput is one operation per WIDTH+2 cycles.
- `cancel` in cycle k forces `stall` = 0 from cycle k+1.

## Configuration
- `DIV_ZERO_FAST_EN` defined:
  - A zero divisor is detected in IDLE at `start`, and the FSM goes directly to DONE.
  - `done` pulses in cycle 1.
  - Result is q = all-ones and r = raw dividend, with no sign correction.
  - `stall` is high only in cycle 0.
- `DIV_ZERO_FAST_EN` undefined: a zero divisor takes the full iterative path and its latency.

## Structure
- Shared header `div_defines.vh`: state encodings (`DIV_IDLE`, `DIV_BUSY`, `DIV_DONE`) and the counter width `$clog2(WIDTH+1)`.
- Sub-module `div_iter`: one combinational restoring step. It takes the partial remainder, the next dividend bit and the divisor, and returns the new remainder and the quotient bit.
- `div_unit` holds the FSM, counter, operand/sign registers and output registers.

## Test plan
All scenarios use WIDTH = 32.
- DIVU 100 / 7 → q = 14, r = 2; `done` in cycle 33; `stall` high in cycles 0..32.
- DIV −7 / 2 (0xFFFFFFF9 / 2) → q = 0xFFFFFFFD, r = 0xFFFFFFFF; DIV 7 / −2 → q = 0xFFFFFFFD, r = 1.
- DIV 0x80000000 / 0xFFFFFFFF → q = 0x80000000, r = 0.
- Complete DIVU 100 / 7, then start DIVU 50 / 3 and assert `cancel` in cycle 10 → no `done`; `stall` = 0 from cycle 11; q stays 14, r stays 2. Then `start` + `cancel` in the same cycle → not accepted.
- DIVU 5 / 0 → q = 0xFFFFFFFF, r = 5; `done` in cycle 1 with `DIV_ZERO_FAST_EN`, in cycle 33 without.
- Reset (`rst` = 0) in cycle 5 of a BUSY operation → next cycle: IDLE, q = 0, r = 0, `done` = 0, `stall` = 0.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared types for the iterative divider: FSM state encoding and counter sizing.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Counter must be able to hold WIDTH itself.
  function automatic int div_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_unit_iter.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  assign w_shift = {i_rem, i_bit};
  assign w_diff  = w_shift - {1'b0, i_dvs};
  // A clear MSB means the trial subtraction did not go negative.
  assign o_qbit  = ~w_diff[WIDTH];
  assign o_rem   = o_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU; one quotient bit per BUSY cycle.
// Optional DIV_ZERO_FAST_EN: zero divisor bypasses the iteration and finishes in one cycle.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [1:0]       dbg_state
);

  localparam int             CW        = div_cnt_w(WIDTH);
  localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH - 1);

  div_state_e       r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dvd, r_dvs, r_rem;
  logic [WIDTH-1:0] r_quotient, r_remainder;
  logic             r_q_neg, r_r_neg;

  logic             w_accept, w_last, w_zero_fast, w_qbit;
  logic [WIDTH-1:0] w_dvd_abs, w_dvs_abs, w_rem_step, w_q_raw;

  // Handshake: a request is taken in IDLE when start=1 and cancel=0; stall stays
  // high from that cycle through the last BUSY cycle, and done pulses once in DONE.
  assign w_accept = (r_state == DIV_IDLE) & start & ~cancel;
  assign w_last   = (r_state == DIV_BUSY) & (r_cnt == LAST_STEP) & ~cancel;

`ifdef DIV_ZERO_FAST_EN
  assign w_zero_fast = w_accept & (divisor == '0);
`else
  assign w_zero_fast = 1'b0;
`endif

  assign w_dvd_abs = (signed_div & dividend[WIDTH-1]) ? -dividend : dividend;
  assign w_dvs_abs = (signed_div & divisor[WIDTH-1])  ? -divisor  : divisor;

  div_iter #(.WIDTH(WIDTH)) u_iter (
    .i_rem  (r_rem),
    .i_bit  (r_dvd[WIDTH-1]),
    .i_dvs  (r_dvs),
    .o_rem  (w_rem_step),
    .o_qbit (w_qbit)
  );

  // Dividend register doubles as the quotient accumulator as bits shift out.
  assign w_q_raw = {r_dvd[WIDTH-2:0], w_qbit};

  always_ff @(posedge clk) begin
    if (!rst) r_state <= DIV_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (cancel) begin
      w_next = DIV_IDLE;
    end else begin
      case (r_state)
        DIV_IDLE: if (start) w_next = w_zero_fast ? DIV_DONE : DIV_BUSY;
        DIV_BUSY: if (r_cnt == LAST_STEP) w_next = DIV_DONE;
        DIV_DONE: w_next = DIV_IDLE;
        default:  w_next = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      if (w_accept) begin
        r_dvd   <= w_dvd_abs;
        r_dvs   <= w_dvs_abs;
        r_rem   <= '0;
        r_cnt   <= '0;
        r_q_neg <= signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        r_r_neg <= signed_div & dividend[WIDTH-1];
      end else if (r_state == DIV_BUSY) begin
        r_rem <= w_rem_step;
        r_dvd <= w_q_raw;
        r_cnt <= r_cnt + CW'(1);
      end
      // Results land on the edge into DONE so they are valid while done is high.
      if (w_zero_fast) begin
        r_quotient  <= '1;
        r_remainder <= dividend;
      end else if (w_last) begin
        r_quotient  <= r_q_neg ? -w_q_raw : w_q_raw;
        r_remainder <= r_r_neg ? -w_rem_step : w_rem_step;
      end
    end
  end

  assign stall     = rst & (w_accept | (r_state == DIV_BUSY));
  assign done      = (r_state == DIV_DONE);
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit (WIDTH=32): results, latency, stall, cancel and reset.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int W = 32;
`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = W + 1;
`endif

  logic         clk = 1'b0;
  logic         rst, start, signed_div, cancel;
  logic [W-1:0] dividend, divisor, quotient, remainder;
  logic         stall, done;
  logic [1:0]   dbg_state;

  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] exp_q[$];

  typedef struct {
    string        name;
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           lat;
  } vec_t;

  vec_t vecs[9];

  div_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .dividend   (dividend),
    .divisor    (divisor),
    .cancel     (cancel),
    .stall      (stall),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // driver: one full operation, checking stall every cycle and results via the scoreboard
  task automatic do_op(input vec_t v);
    int lat;
    logic [2*W-1:0] e;
    exp_q.push_back({v.q, v.r});
    @(negedge clk);
    signed_div = v.s; dividend = v.a; divisor = v.b; start = 1'b1;
    #1;
    check({v.name, " stall_c0"}, 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = $urandom; divisor = $urandom;
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      check($sformatf("%s stall_c%0d", v.name, c), 32'(stall), (c < v.lat) ? 32'd1 : 32'd0);
      if (done) begin
        lat = c;
        break;
      end
    end
    e = exp_q.pop_front();
    check({v.name, " latency"}, 32'(lat), 32'(v.lat));
    if (lat >= 0) begin
      check({v.name, " quotient"}, quotient, e[2*W-1:W]);
      check({v.name, " remainder"}, remainder, e[W-1:0]);
    end
    @(negedge clk);
    check({v.name, " done_pulse"}, 32'(done), 32'd0);
    check({v.name, " stall_idle"}, 32'(stall), 32'd0);
  endtask

  initial begin
    vecs[0] = '{"divu_100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          W + 1};
    vecs[1] = '{"div_m7_2",     1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  W + 1};
    vecs[2] = '{"div_7_m2",     1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          W + 1};
    vecs[3] = '{"div_min_m1",   1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          W + 1};
    vecs[4] = '{"divu_5_0",     1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          ZLAT};
    vecs[5] = '{"div_m100_7",   1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  W + 1};
    vecs[6] = '{"divu_max_16",  1'b0, 32'hFFFF_FFFF,  32'd16,         32'h0FFF_FFFF,  32'd15,         W + 1};
    vecs[7] = '{"divu_3_5",     1'b0, 32'd3,          32'd5,          32'd0,          32'd3,          W + 1};
    vecs[8] = '{"divu_min_max", 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  W + 1};

    // reset state, with start held high to prove stall is forced low
    rst = 1'b0; start = 1'b1; cancel = 1'b0; signed_div = 1'b0;
    dividend = 32'd100; divisor = 32'd7;
    repeat (3) @(negedge clk);
    check("rst stall", 32'(stall), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst quotient", quotient, 32'd0);
    check("rst remainder", remainder, 32'd0);
    check("rst state", 32'(dbg_state), 32'(DIV_IDLE));
    start = 1'b0; rst = 1'b1;

    for (int i = 0; i < 9; i++) do_op(vecs[i]);

    // cancel mid-operation: outputs keep the previous result
    do_op(vecs[0]);
    @(negedge clk);
    signed_div = 1'b0; dividend = 32'd50; divisor = 32'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      check($sformatf("cancel stall_c%0d", c), 32'(stall), 32'd1);
    end
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    for (int c = 11; c <= 45; c++) begin
      @(negedge clk);
      check($sformatf("cancel stall_c%0d", c), 32'(stall), 32'd0);
      check($sformatf("cancel done_c%0d", c), 32'(done), 32'd0);
    end
    check("cancel quotient", quotient, 32'd14);
    check("cancel remainder", remainder, 32'd2);

    // start and cancel together: request must not be taken
    @(negedge clk);
    dividend = 32'd50; divisor = 32'd3; start = 1'b1; cancel = 1'b1;
    #1;
    check("startcancel stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0; cancel = 1'b0;
    check("startcancel state", 32'(dbg_state), 32'(DIV_IDLE));
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      check($sformatf("startcancel done_c%0d", c), 32'(done), 32'd0);
      check($sformatf("startcancel stall_c%0d", c), 32'(stall), 32'd0);
    end
    check("startcancel quotient", quotient, 32'd14);

    // reset in cycle 5 of a BUSY operation
    @(negedge clk);
    signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd9; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check("busyrst stall_low", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    check("busyrst state", 32'(dbg_state), 32'(DIV_IDLE));
    check("busyrst quotient", quotient, 32'd0);
    check("busyrst remainder", remainder, 32'd0);
    check("busyrst done", 32'(done), 32'd0);
    check("busyrst stall", 32'(stall), 32'd0);
    rst = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      check($sformatf("busyrst done_c%0d", c), 32'(done), 32'd0);
    end

    // recovery after reset
    do_op(vecs[1]);
    do_op(vecs[4]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
